// File: rtl/mem_bus_if.sv
// Unified memory bus between the memory access unit (master) and memory (slave).
// One registered request held until a single-cycle acknowledge.
interface mem_bus_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle RV32 core: converts FSM memory strobes into
// req/ack bus transactions, owns IR/OldPC/Data registers and stalls the FSM meanwhile.
module mem_access_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     TO_CYCLES = 255,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_ir,
    input  logic            sel_mem_addr,
    input  logic            we_mem,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] data_reg,
    output logic            bus_err,
    mem_bus_if.master       bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              req_d, we_d, err_d;
    logic [XLEN-1:0]   addr_d, wdata_d, instr_d, old_pc_d, data_d;
    logic              acc, fetch, load, fault;
    logic [XLEN-1:0]   addr;

    // Access decode from the FSM strobes
    always_comb begin
        acc   = we_ir | sel_mem_addr | we_mem;
        addr  = sel_mem_addr ? alu_out : pc;
        fetch = we_ir;
        load  = sel_mem_addr & ~we_mem;
        stall = acc & (state != DONE);
    end

    // Next-state and register update logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        req_d    = bus.mem_req;
        we_d     = bus.mem_we;
        addr_d   = bus.mem_addr;
        wdata_d  = bus.mem_wdata;
        instr_d  = instr;
        old_pc_d = old_pc;
        data_d   = data_reg;
        err_d    = bus_err;
        fault    = 1'b0;

        case (state)
            IDLE: begin
                if (acc) begin
                    if (addr[1:0] == 2'b00) begin
                        req_d   = 1'b1;
                        we_d    = we_mem;
                        addr_d  = addr;
                        wdata_d = wdata;
                        state_d = BUSY;
                    end else begin
                        err_d   = 1'b1;
                        fault   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                // An ack in the timeout cycle takes priority over the timeout
                if (bus.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (fetch) begin
                        instr_d  = bus.mem_rdata;
                        old_pc_d = pc;
                    end else if (load) begin
                        data_d = bus.mem_rdata;
                    end
                end else if (cnt == CNT_W'(TO_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    fault   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Faulted fetch executes a NOP; faulted load returns zero; store is dropped
        if (fault) begin
            if (fetch) begin
                instr_d  = NOP_INSTR;
                old_pc_d = pc;
            end else if (load) begin
                data_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            instr         <= NOP_INSTR;
            old_pc        <= '0;
            data_reg      <= '0;
            bus_err       <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            bus.mem_req   <= req_d;
            bus.mem_we    <= we_d;
            bus.mem_addr  <= addr_d;
            bus.mem_wdata <= wdata_d;
            instr         <= instr_d;
            old_pc        <= old_pc_d;
            data_reg      <= data_d;
            bus_err       <= err_d;
        end
    end
endmodule
